tinyqv_slice_sequencer: RTL and testbench
=========================================

Name: tinyqv_slice_sequencer

Overview:
Generic slice-serial operand sequencer for the tinyQV nibble-serial datapath. It captures N_CH parallel XLEN-bit operands (imm, pc, load data, ...) on a start handshake and presents them one SLICE_W-bit slice per cycle, LSB slice first, with a slice index for the core. In the same cycles it collects the core's result slices into a parallel XLEN-bit word and pulses out_valid when the word is complete. It supports stall and back-to-back operation, and replaces the ad-hoc free-running counter and slicing logic used around the core today.

Parameters:
XLEN, 32, operand and result width in bits.
SLICE_W, 4, bits per slice. XLEN % SLICE_W == 0 is required.
N_CH, 3, number of input operand channels.
Derived: NS = XLEN/SLICE_W, a power of 2 and >= 2. IDX_W = $clog2(NS).

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
start  in  1  request a new operation. Sampled only when ready=1.
stall  in  1  freeze sequencing for this cycle
in_words  in  N_CH*XLEN  operands. Channel c occupies bits [c*XLEN +: XLEN]. Sampled at accepted start.
ready  out  1  combinational: !busy | (last & !stall)
in_slices  out  N_CH*SLICE_W  current slice of each channel. Channel c occupies bits [c*SLICE_W +: SLICE_W].
slice_idx  out  IDX_W  index of the current slice, 0..NS-1
busy  out  1  sequencing in progress
first  out  1  busy & slice_idx==0
last  out  1  busy & slice_idx==NS-1
out_slice  in  SLICE_W  core result slice for slice_idx. Valid while busy.
out_word  out  XLEN  assembled result. Holds until the next completion.
out_valid  out  1  one-cycle pulse: out_word was updated

Behaviour:
- Reset (rstn=0 at an edge): busy=0, slice_idx=0, in_slices=0, out_word=0, out_valid=0, and all shift state cleared. Reset mid-operation abandons the operation; no out_valid is produced.
- States: IDLE (busy=0) and RUN (busy=1). The slice counter is only meaningful in RUN.
- Accept: an edge with start & ready loads every channel shifter from in_words, sets slice_idx=0 and busy=1. in_slices show slice 0 in the following cycle, so latency from start to first slice is 1 cycle.
- Advance in RUN when stall=0, at each edge:
  - capture out_slice into out_word staging bits [slice_idx*SLICE_W +: SLICE_W];
  - shift each channel right by SLICE_W;
  - increment slice_idx.
- Stall=1: counter, shifters and staging all hold; out_slice is ignored. Stall in IDLE has no effect.
- Completion: at the advancing edge while last=1, the staging register including the final slice is copied to out_word and out_valid=1 for exactly the next cycle. If no start was accepted at that edge, busy=0 and slice_idx wraps to 0. An operation therefore occupies exactly NS unstalled cycles, and out_valid follows 1 cycle after the last slice.
- Back-to-back: start during last & !stall is accepted at the same edge as completion. The next cycle then has busy=1, slice_idx=0 with the new operands, and out_valid=1 for the previous word, so there are no bubbles.
- start while busy & !last, or during a stalled last cycle, is ignored (ready=0). The requester must hold start.
- in_words changes after the accepting edge do not affect the operation in flight.
- out_word is never partially updated; intermediate slices go only to staging.
- in_slices are registered (shifter LSBs), with no combinational path from in_words. ready, first and last are combinational from state and stall.

Decomposition:
- Package tinyqv_slice_pkg: function computing NS and IDX_W from XLEN and SLICE_W, plus elaboration-time checks for divisibility and power-of-2 NS.
- Sub-module tinyqv_slice_shifter (XLEN, SLICE_W): load/shift/hold register with the slice output. It is instantiated N_CH times via generate. Staging, counter and FSM stay in the top.

Test Plan:
- Defaults, channels {0x12345678, 0xCAFEF00D, 0x0}, out_slice looped back from ch0 slice, start 1 cycle -> ch0 slices 8,7,6,5,4,3,2,1 with slice_idx 0..7. first at idx 0, last at idx 7. out_word=0x12345678 with out_valid 1 cycle after last. busy=0 afterwards.
- Same operation with stall high on idx 3 for 2 cycles -> slice 5 held 3 cycles. out_valid arrives 2 cycles later than unstalled and out_word is unchanged (0x12345678).
- Back-to-back: second start with ch0=0xA5A5A5A5 held from the last cycle -> idx 0 of op 2 coincides with out_valid for op 1 (0x12345678). out_valid for op 2 follows 8 cycles later with 0xA5A5A5A5. No idle cycle in between.
- start pulsed at idx 4 -> ignored (ready=0). in_words changed mid-operation -> slices still come from the captured value.
- rstn low at idx 5 -> next cycle busy=0, in_slices=0, out_valid never asserts, out_word=0. A fresh start then runs normally.
- SLICE_W=8, XLEN=32, N_CH=2, ch1=0xDEADBEEF looped back -> slices EF,BE,AD,DE with idx 0..3. out_word=0xDEADBEEF after 4 slices.

Source files
------------

// File: rtl/tinyqv_slice_pkg.sv
// Shared sizing helpers and FSM encodings for the tinyQV slice sequencer.
package tinyqv_slice_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  function automatic int calc_ns(input int xlen, input int slice_w);
    return (slice_w > 0) ? (xlen / slice_w) : 0;
  endfunction

  function automatic int calc_idx_w(input int xlen, input int slice_w);
    return $clog2(calc_ns(xlen, slice_w));
  endfunction

  // Slices must tile the word exactly and the slice count must be a power of 2 >= 2.
  function automatic bit cfg_ok(input int xlen, input int slice_w);
    int ns;
    if (slice_w <= 0) begin
      return 1'b0;
    end else begin
      ns = xlen / slice_w;
      return ((xlen % slice_w) == 0) && (ns >= 2) && ((ns & (ns - 1)) == 0);
    end
  endfunction

endpackage

// File: rtl/tinyqv_slice_shifter.sv
// One operand channel: parallel load, right shift by one slice, hold otherwise.
module tinyqv_slice_shifter #(
  parameter int XLEN    = 32,
  parameter int SLICE_W = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [XLEN-1:0]    data_i,
  output logic [SLICE_W-1:0] slice_o
);

  logic [XLEN-1:0] sr_q, sr_d;

  // Load has priority so a back-to-back accept overrides the final shift.
  always_comb begin
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = sr_q >> SLICE_W;
    end else begin
      sr_d = sr_q;
    end
  end

  // Shift register state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sr_q <= {XLEN{1'b0}};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign slice_o = sr_q[SLICE_W-1:0];

endmodule

// File: rtl/tinyqv_slice_sequencer.sv
// Presents N_CH captured operands one slice per cycle and reassembles the
// core's result slices into a parallel word.
module tinyqv_slice_sequencer
  import tinyqv_slice_pkg::*;
#(
  parameter int  XLEN    = 32,
  parameter int  SLICE_W = 4,
  parameter int  N_CH    = 3,
  localparam int NS      = calc_ns(XLEN, SLICE_W),
  localparam int IDX_W   = calc_idx_w(XLEN, SLICE_W)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      stall,
  input  logic [N_CH*XLEN-1:0]      in_words,
  output logic                      ready,
  output logic [N_CH*SLICE_W-1:0]   in_slices,
  output logic [IDX_W-1:0]          slice_idx,
  output logic                      busy,
  output logic                      first,
  output logic                      last,
  input  logic [SLICE_W-1:0]        out_slice,
  output logic [XLEN-1:0]           out_word,
  output logic                      out_valid
);

  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NS - 1);

  if (!cfg_ok(XLEN, SLICE_W)) begin : g_bad_cfg
    $error("tinyqv_slice_sequencer: XLEN/SLICE_W must be a power of 2 >= 2");
  end

  logic             state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]  stage_q, stage_d;
  logic [XLEN-1:0]  out_word_q, out_word_d;
  logic             out_valid_q, out_valid_d;
  logic             accept_s, advance_s, shift_s;

  assign busy      = (state_q == ST_RUN);
  assign first     = busy & (idx_q == IDX_ZERO);
  assign last      = busy & (idx_q == IDX_LAST);
  assign ready     = ~busy | (last & ~stall);
  assign accept_s  = start & ready;
  assign advance_s = busy & ~stall;
  assign shift_s   = advance_s & ~accept_s;

  // Sequencing FSM and slice counter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (accept_s) begin
      state_d = ST_RUN;
      idx_d   = IDX_ZERO;
    end else if (advance_s && last) begin
      state_d = ST_IDLE;
      idx_d   = IDX_ZERO;
    end else if (advance_s) begin
      idx_d   = idx_q + IDX_W'(1);
    end else begin
      idx_d   = idx_q;
    end
  end

  // Result staging; out_word only ever takes a fully assembled word.
  always_comb begin
    stage_d     = stage_q;
    out_word_d  = out_word_q;
    out_valid_d = 1'b0;
    if (advance_s) begin
      for (int s = 0; s < NS; s++) begin
        if (idx_q == IDX_W'(s)) begin
          stage_d[s*SLICE_W +: SLICE_W] = out_slice;
        end else begin
          stage_d[s*SLICE_W +: SLICE_W] = stage_q[s*SLICE_W +: SLICE_W];
        end
      end
      if (last) begin
        out_word_d  = stage_d;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      stage_d = stage_q;
    end
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      idx_q       <= IDX_ZERO;
      stage_q     <= {XLEN{1'b0}};
      out_word_q  <= {XLEN{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stage_q     <= stage_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    tinyqv_slice_shifter #(
      .XLEN    (XLEN),
      .SLICE_W (SLICE_W)
    ) u_shifter (
      .clk     (clk),
      .rstn    (rstn),
      .load_i  (accept_s),
      .shift_i (shift_s),
      .data_i  (in_words[c*XLEN +: XLEN]),
      .slice_o (in_slices[c*SLICE_W +: SLICE_W])
    );
  end

  assign slice_idx = idx_q;
  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_tinyqv_slice_sequencer.sv
// Directed bench: default 4-bit slicing instance plus an 8-bit slice, 2-channel instance.
module tb_tinyqv_slice_sequencer;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Instance A: XLEN=32, SLICE_W=4, N_CH=3
  logic        start_a = 1'b0, stall_a = 1'b0;
  logic [95:0] in_words_a = 96'h0;
  logic        ready_a, busy_a, first_a, last_a, out_valid_a;
  logic [11:0] in_slices_a;
  logic [2:0]  idx_a;
  logic [3:0]  out_slice_a;
  logic [31:0] out_word_a;

  // Instance B: XLEN=32, SLICE_W=8, N_CH=2
  logic        start_b = 1'b0, stall_b = 1'b0;
  logic [63:0] in_words_b = 64'h0;
  logic        ready_b, busy_b, first_b, last_b, out_valid_b;
  logic [15:0] in_slices_b;
  logic [1:0]  idx_b;
  logic [7:0]  out_slice_b;
  logic [31:0] out_word_b;

  assign out_slice_a = in_slices_a[3:0];
  assign out_slice_b = in_slices_b[15:8];

  tinyqv_slice_sequencer u_dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .stall(stall_a), .in_words(in_words_a),
    .ready(ready_a), .in_slices(in_slices_a), .slice_idx(idx_a), .busy(busy_a),
    .first(first_a), .last(last_a), .out_slice(out_slice_a), .out_word(out_word_a),
    .out_valid(out_valid_a)
  );

  tinyqv_slice_sequencer #(.XLEN(32), .SLICE_W(8), .N_CH(2)) u_dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .stall(stall_b), .in_words(in_words_b),
    .ready(ready_b), .in_slices(in_slices_b), .slice_idx(idx_b), .busy(busy_b),
    .first(first_b), .last(last_b), .out_slice(out_slice_b), .out_word(out_word_b),
    .out_valid(out_valid_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op_a(input logic [31:0] w0);
    in_words_a = {32'h0000_0000, 32'hCAFE_F00D, w0};
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({busy_a, first_a, last_a, ready_a, out_valid_a} !== 5'b00010) begin
      tests_failed++;
      $display("FAIL reset_ctrl_a got %b exp 00010", {busy_a, first_a, last_a, ready_a, out_valid_a});
    end
    tests_run++;
    if (idx_a !== 3'd0 || in_slices_a !== 12'h000 || out_word_a !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data_a got idx=%0d sl=%h w=%h exp 0", idx_a, in_slices_a, out_word_a);
    end
    tests_run++;
    if (busy_b !== 1'b0 || out_word_b !== 32'h0 || in_slices_b !== 16'h0 || out_valid_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_b got busy=%b w=%h sl=%h ov=%b exp 0", busy_b, out_word_b, in_slices_b, out_valid_b);
    end
  endtask

  task automatic test_idle_stall();
    stall_a = 1'b1;
    step();
    step();
    tests_run++;
    if (busy_a !== 1'b0 || idx_a !== 3'd0 || ready_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_stall got busy=%b idx=%0d ready=%b exp 0 0 1", busy_a, idx_a, ready_a);
    end
    stall_a = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] w;
    logic [31:0] w1;
    w = 32'h1234_5678;
    w1 = 32'hCAFE_F00D;
    start_op_a(w);
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (idx_a !== 3'(k) || in_slices_a[3:0] !== w[k*4 +: 4] || in_slices_a[7:4] !== w1[k*4 +: 4]) begin
        tests_failed++;
        $display("FAIL basic_slice k=%0d got idx=%0d s0=%h s1=%h exp %0d %h %h",
                 k, idx_a, in_slices_a[3:0], in_slices_a[7:4], k, w[k*4 +: 4], w1[k*4 +: 4]);
      end
      tests_run++;
      if ({busy_a, first_a, last_a, out_valid_a} !== {1'b1, (k == 0), (k == 7), 1'b0}) begin
        tests_failed++;
        $display("FAIL basic_flags k=%0d got %b exp %b", k, {busy_a, first_a, last_a, out_valid_a},
                 {1'b1, (k == 0), (k == 7), 1'b0});
      end
      step();
    end
    tests_run++;
    if (out_valid_a !== 1'b1 || out_word_a !== w || busy_a !== 1'b0 || idx_a !== 3'd0) begin
      tests_failed++;
      $display("FAIL basic_done got ov=%b w=%h busy=%b idx=%0d exp 1 %h 0 0", out_valid_a, out_word_a, busy_a, idx_a, w);
    end
    step();
    tests_run++;
    if (out_valid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_pulse got ov=%b exp 0", out_valid_a);
    end
  endtask

  task automatic test_stall();
    logic [31:0] w;
    int exp_idx;
    w = 32'h1234_5678;
    start_op_a(w);
    for (int c = 0; c <= 10; c++) begin
      exp_idx = (c < 3) ? c : ((c <= 5) ? 3 : c - 2);
      tests_run++;
      if (c < 10) begin
        if (busy_a !== 1'b1 || idx_a !== 3'(exp_idx) || in_slices_a[3:0] !== w[exp_idx*4 +: 4] || out_valid_a !== 1'b0) begin
          tests_failed++;
          $display("FAIL stall_seq c=%0d got busy=%b idx=%0d s=%h ov=%b exp 1 %0d %h 0",
                   c, busy_a, idx_a, in_slices_a[3:0], out_valid_a, exp_idx, w[exp_idx*4 +: 4]);
        end
      end else begin
        if (out_valid_a !== 1'b1 || out_word_a !== w || busy_a !== 1'b0) begin
          tests_failed++;
          $display("FAIL stall_done got ov=%b w=%h busy=%b exp 1 %h 0", out_valid_a, out_word_a, busy_a, w);
        end
      end
      stall_a = (c == 3 || c == 4);
      step();
    end
    stall_a = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1;
    logic [31:0] w2;
    w1 = 32'h1234_5678;
    w2 = 32'hA5A5_A5A5;
    start_op_a(w1);
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (idx_a !== 3'(k) || in_slices_a[3:0] !== w1[k*4 +: 4]) begin
        tests_failed++;
        $display("FAIL b2b_op1 k=%0d got idx=%0d s=%h exp %0d %h", k, idx_a, in_slices_a[3:0], k, w1[k*4 +: 4]);
      end
      if (k == 7) begin
        tests_run++;
        if (ready_a !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_ready got %b exp 1", ready_a);
        end
        in_words_a = {32'h0000_0000, 32'hCAFE_F00D, w2};
        start_a = 1'b1;
      end
      step();
    end
    start_a = 1'b0;
    tests_run++;
    if (out_valid_a !== 1'b1 || out_word_a !== w1 || busy_a !== 1'b1 || first_a !== 1'b1 || in_slices_a[3:0] !== w2[3:0]) begin
      tests_failed++;
      $display("FAIL b2b_overlap got ov=%b w=%h busy=%b first=%b s=%h exp 1 %h 1 1 %h",
               out_valid_a, out_word_a, busy_a, first_a, in_slices_a[3:0], w1, w2[3:0]);
    end
    step();
    for (int k = 1; k < 8; k++) begin
      tests_run++;
      if (idx_a !== 3'(k) || in_slices_a[3:0] !== w2[k*4 +: 4] || out_valid_a !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_op2 k=%0d got idx=%0d s=%h ov=%b exp %0d %h 0", k, idx_a, in_slices_a[3:0], out_valid_a, k, w2[k*4 +: 4]);
      end
      step();
    end
    tests_run++;
    if (out_valid_a !== 1'b1 || out_word_a !== w2 || busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_done got ov=%b w=%h busy=%b exp 1 %h 0", out_valid_a, out_word_a, busy_a, w2);
    end
  endtask

  task automatic test_ignored_start();
    logic [31:0] w;
    w = 32'h8765_4321;
    start_op_a(w);
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (idx_a !== 3'(k) || in_slices_a[3:0] !== w[k*4 +: 4]) begin
        tests_failed++;
        $display("FAIL ign_slice k=%0d got idx=%0d s=%h exp %0d %h", k, idx_a, in_slices_a[3:0], k, w[k*4 +: 4]);
      end
      if (k == 4) begin
        tests_run++;
        if (ready_a !== 1'b0) begin
          tests_failed++;
          $display("FAIL ign_ready got %b exp 0", ready_a);
        end
        start_a = 1'b1;
        in_words_a = {32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
      end else begin
        start_a = 1'b0;
      end
      step();
    end
    tests_run++;
    if (out_valid_a !== 1'b1 || out_word_a !== w || busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL ign_done got ov=%b w=%h busy=%b exp 1 %h 0", out_valid_a, out_word_a, busy_a, w);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] w;
    logic seen_valid;
    int cyc;
    w = 32'h0F1E_2D3C;
    start_op_a(w);
    for (int k = 0; k < 5; k++) step();
    tests_run++;
    if (idx_a !== 3'd5) begin
      tests_failed++;
      $display("FAIL rst_pre got idx=%0d exp 5", idx_a);
    end
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    tests_run++;
    if (busy_a !== 1'b0 || in_slices_a !== 12'h000 || out_word_a !== 32'h0 || idx_a !== 3'd0 || out_valid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid got busy=%b sl=%h w=%h idx=%0d ov=%b exp 0 000 0 0 0",
               busy_a, in_slices_a, out_word_a, idx_a, out_valid_a);
    end
    seen_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid_a === 1'b1) seen_valid = 1'b1;
      step();
    end
    tests_run++;
    if (seen_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_no_valid got %b exp 0", seen_valid);
    end
    start_op_a(w);
    cyc = 0;
    while (out_valid_a !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    tests_run++;
    if (cyc !== 8 || out_word_a !== w) begin
      tests_failed++;
      $display("FAIL rst_fresh got cycles=%0d w=%h exp 8 %h", cyc, out_word_a, w);
    end
  endtask

  task automatic test_wide_slices();
    logic [31:0] w1;
    logic [31:0] w0;
    w1 = 32'hDEAD_BEEF;
    w0 = 32'h0102_0304;
    in_words_b = {w1, w0};
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (idx_b !== 2'(k) || in_slices_b[15:8] !== w1[k*8 +: 8] || in_slices_b[7:0] !== w0[k*8 +: 8] || last_b !== (k == 3)) begin
        tests_failed++;
        $display("FAIL wide_slice k=%0d got idx=%0d s1=%h s0=%h last=%b exp %0d %h %h %b",
                 k, idx_b, in_slices_b[15:8], in_slices_b[7:0], last_b, k, w1[k*8 +: 8], w0[k*8 +: 8], (k == 3));
      end
      step();
    end
    tests_run++;
    if (out_valid_b !== 1'b1 || out_word_b !== w1 || busy_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL wide_done got ov=%b w=%h busy=%b exp 1 %h 0", out_valid_b, out_word_b, busy_b, w1);
    end
  endtask

  initial begin
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    test_reset();
    test_idle_stall();
    test_basic();
    test_stall();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid_op();
    test_wide_slices();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
